spy_path_sampler: RTL and testbench

Launch/capture controller for the chained spy delay paths. It drives the chain input with a toggling launch register and samples the chain output a fixed number of clock cycles after each launch. It compares each sample against the expected settled value and accumulates separate mismatch counts for rising and falling launches over a measurement window. The counts are the timing-violation signature that software reads to detect delay shifts in the chained path.

---
 rtl/spy_path_sampler.sv | 143 ++++++++++++++
 tb/tb_spy_path_sampler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_path_sampler.sv
`timescale 1ns/1ps
// Launch/capture controller for the chained spy delay paths: toggles the launch register,
// samples the chain output SAMPLE_CYCLES later, and counts rise/fall mismatches per window.
module spy_path_sampler #(
    parameter int unsigned SAMPLE_CYCLES = 1,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned WINDOW        = 256,
    parameter int unsigned CNT_W         = 16,
    parameter bit          INVERT        = 1'b0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    output logic             pathInput,
    input  logic             pathResult,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] errRise,
    output logic [CNT_W-1:0] errFall,
    output logic             lastSample
);

    localparam int unsigned TRIAL_W = 16;
    localparam int unsigned DLY_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam logic [TRIAL_W-1:0] TRIAL_LAST = TRIAL_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_path, w_path_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_last, w_last_nxt;
    logic [CNT_W-1:0]   r_rise, w_rise_nxt;
    logic [CNT_W-1:0]   r_fall, w_fall_nxt;
    logic [TRIAL_W-1:0] r_trial, w_trial_nxt;
    logic [DLY_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_mismatch;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_path  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= 1'b0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_trial <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_path  <= w_path_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_last  <= w_last_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_trial <= w_trial_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; r_cnt serves as wait counter in WAIT and settle counter in SETTLE.
    always_comb begin
        w_state_nxt = r_state;
        w_path_nxt  = r_path;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_last_nxt  = r_last;
        w_rise_nxt  = r_rise;
        w_fall_nxt  = r_fall;
        w_trial_nxt = r_trial;
        w_cnt_nxt   = r_cnt;
        w_mismatch  = (r_last != (r_path ^ INVERT));

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_path_nxt  = ~r_path;
                    w_rise_nxt  = '0;
                    w_fall_nxt  = '0;
                    w_trial_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = DLY_W'(SAMPLE_CYCLES - 1);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_last_nxt  = pathResult;
                    w_state_nxt = ST_EVAL;
                end else begin
                    w_cnt_nxt = r_cnt - DLY_W'(1);
                end
            end
            ST_EVAL: begin
                if (w_mismatch) begin
                    if (r_path) begin
                        if (r_rise != CNT_MAX) w_rise_nxt = r_rise + CNT_W'(1);
                    end else begin
                        if (r_fall != CNT_MAX) w_fall_nxt = r_fall + CNT_W'(1);
                    end
                end
                w_trial_nxt = r_trial + TRIAL_W'(1);
                if (r_trial == TRIAL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = DLY_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_path_nxt  = ~r_path;
                    w_cnt_nxt   = DLY_W'(SAMPLE_CYCLES - 1);
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - DLY_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign pathInput  = r_path;
    assign busy       = r_busy;
    assign done       = r_done;
    assign lastSample = r_last;
    assign errRise    = r_rise;
    assign errFall    = r_fall;

endmodule

// File: tb/tb_spy_path_sampler.sv
`timescale 1ns/1ps
// Bench for spy_path_sampler: four instances (W=4, W=3, 2-bit counters W=16, inverting) on
// transport-delay chain models, checked each cycle against a window-arithmetic model.
module tb_spy_path_sampler;

    localparam int N    = 4;
    localparam int SMP  = 1;
    localparam int SET  = 2;
    localparam int P    = SMP + SET + 1;
    localparam int TCLK = 10;

    logic        clk;
    logic        rst_n;
    logic        start_s  [N];
    logic        path_in  [N];
    logic        path_res [N];
    logic        busy_s   [N];
    logic        done_s   [N];
    logic        last_s   [N];
    logic [15:0] err_r    [N];
    logic [15:0] err_f    [N];
    logic [1:0]  er2, ef2;

    int rise_d [N];
    int fall_d [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, one entry per instance
    bit m_act  [N];
    int m_rel  [N];
    bit m_p0   [N];
    bit m_pin  [N];
    bit m_busy [N];
    bit m_done [N];
    bit m_last [N];
    int m_er   [N];
    int m_ef   [N];

    spy_path_sampler #(.SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(SET), .WINDOW(4), .CNT_W(16), .INVERT(1'b0)) u0 (
        .clk(clk), .resetN(rst_n), .start(start_s[0]), .pathInput(path_in[0]), .pathResult(path_res[0]),
        .busy(busy_s[0]), .done(done_s[0]), .errRise(err_r[0]), .errFall(err_f[0]), .lastSample(last_s[0]));

    spy_path_sampler #(.SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(SET), .WINDOW(3), .CNT_W(16), .INVERT(1'b0)) u1 (
        .clk(clk), .resetN(rst_n), .start(start_s[1]), .pathInput(path_in[1]), .pathResult(path_res[1]),
        .busy(busy_s[1]), .done(done_s[1]), .errRise(err_r[1]), .errFall(err_f[1]), .lastSample(last_s[1]));

    spy_path_sampler #(.SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(SET), .WINDOW(16), .CNT_W(2), .INVERT(1'b0)) u2 (
        .clk(clk), .resetN(rst_n), .start(start_s[2]), .pathInput(path_in[2]), .pathResult(path_res[2]),
        .busy(busy_s[2]), .done(done_s[2]), .errRise(er2), .errFall(ef2), .lastSample(last_s[2]));

    spy_path_sampler #(.SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(SET), .WINDOW(4), .CNT_W(16), .INVERT(1'b1)) u3 (
        .clk(clk), .resetN(rst_n), .start(start_s[3]), .pathInput(path_in[3]), .pathResult(path_res[3]),
        .busy(busy_s[3]), .done(done_s[3]), .errRise(err_r[3]), .errFall(err_f[3]), .lastSample(last_s[3]));

    assign err_r[2] = {14'b0, er2};
    assign err_f[2] = {14'b0, ef2};

    // Transport-delay chain; instance 3 has an inverting output stage.
    for (genvar g = 0; g < N; g++) begin : g_chain
        logic q;
        always @(path_in[g]) q <= #(path_in[g] ? rise_d[g] : fall_d[g]) path_in[g];
        assign path_res[g] = q ^ (g == 3);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int win_of(input int i);
        case (i)
            1:       return 3;
            2:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int cap_of(input int i);
        return (i == 2) ? 3 : 65535;
    endfunction

    function automatic bit inv_of(input int i);
        return (i == 3);
    endfunction

    function automatic bit late_of(input int i, input bit dir);
        return (dir ? rise_d[i] : fall_d[i]) > SMP * TCLK;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    // Window model: launches at rel k*P, captures at k*P+SMP, evaluations at k*P+SMP+1.
    task automatic model_step(input int i, input bit r, input bit s);
        int rel, w, k, nl;
        bit dir;
        if (!r) begin
            m_act[i] = 0; m_rel[i] = 0; m_pin[i] = 0; m_busy[i] = 0;
            m_done[i] = 0; m_last[i] = 0; m_er[i] = 0; m_ef[i] = 0;
            return;
        end
        m_done[i] = 1'b0;
        if (m_act[i]) m_rel[i] = m_rel[i] + 1;
        else if (s) begin
            m_act[i] = 1; m_rel[i] = 0; m_p0[i] = m_pin[i]; m_er[i] = 0; m_ef[i] = 0;
        end
        if (m_act[i]) begin
            rel = m_rel[i];
            w   = win_of(i);
            nl  = rel / P + 1;
            if (nl > w) nl = w;
            m_pin[i] = m_p0[i] ^ nl[0];
            if (rel >= SMP && (rel - SMP) % P == 0 && (rel - SMP) / P < w) begin
                k   = (rel - SMP) / P;
                dir = m_p0[i] ^ (k[0] == 1'b0);
                m_last[i] = (late_of(i, dir) ? ~dir : dir) ^ inv_of(i);
            end
            if (rel >= SMP + 1 && (rel - SMP - 1) % P == 0) begin
                k   = (rel - SMP - 1) / P;
                dir = m_p0[i] ^ (k[0] == 1'b0);
                if (late_of(i, dir)) begin
                    if (dir) m_er[i] = (m_er[i] < cap_of(i)) ? m_er[i] + 1 : m_er[i];
                    else     m_ef[i] = (m_ef[i] < cap_of(i)) ? m_ef[i] + 1 : m_ef[i];
                end
                if (k == w - 1) begin
                    m_act[i]  = 0;
                    m_done[i] = 1;
                end
            end
        end
        m_busy[i] = m_act[i];
    endtask

    // Per-cycle compare of every instance against the model.
    initial begin : compare
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) model_step(i, rst_n, start_s[i]);
            #1;
            for (int i = 0; i < N; i++) begin
                chk("cyc_pathInput",  i, path_in[i], m_pin[i]);
                chk("cyc_busy",       i, busy_s[i],  m_busy[i]);
                chk("cyc_done",       i, done_s[i],  m_done[i]);
                chk("cyc_lastSample", i, last_s[i],  m_last[i]);
                chk("cyc_errRise",    i, err_r[i],   m_er[i]);
                chk("cyc_errFall",    i, err_f[i],   m_ef[i]);
            end
        end
    end

    task automatic pulse_start(input int i);
        @(negedge clk);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output int cyc);
        cyc = 0;
        while (done_s[i] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", i, done_s[i], 1);
    endtask

    task automatic chk_counts(input string nm, input int i, input int er, input int ef);
        chk({nm, "_errRise"}, i, err_r[i], er);
        chk({nm, "_errFall"}, i, err_f[i], ef);
        chk({nm, "_model_er"}, i, m_er[i], er);
        chk({nm, "_model_ef"}, i, m_ef[i], ef);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) start_s[i] = 1'b0;
        rise_d[0] = 3;  fall_d[0] = 3;
        rise_d[1] = 14; fall_d[1] = 3;
        rise_d[2] = 14; fall_d[2] = 14;
        rise_d[3] = 3;  fall_d[3] = 3;

        // Reset held for three edges
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_pathInput", i, path_in[i], 0);
            chk("rst_busy", i, busy_s[i], 0);
            chk("rst_done", i, done_s[i], 0);
            chk("rst_lastSample", i, last_s[i], 0);
            chk_counts("rst", i, 0, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fast path: busy for 14 cycles after the start edge, then one-cycle done
        pulse_start(0);
        chk("fast_busy", 0, busy_s[0], 1);
        chk("fast_launch_pin", 0, path_in[0], 1);
        for (int c = 1; c < 14; c++) begin
            @(negedge clk);
            chk("fast_busy", 0, busy_s[0], 1);
            chk("fast_done_early", 0, done_s[0], 0);
        end
        @(negedge clk);
        chk("fast_busy_end", 0, busy_s[0], 0);
        chk("fast_done", 0, done_s[0], 1);
        chk("fast_pin_end", 0, path_in[0], 0);
        chk_counts("fast", 0, 0, 0);
        @(negedge clk);
        chk("fast_done_pulse", 0, done_s[0], 0);

        // Slow path: every launch misses
        rise_d[0] = 14; fall_d[0] = 14;
        repeat (2) @(negedge clk);
        pulse_start(0);
        wait_done(0, 40, cyc);
        chk("slow_len", 0, cyc, 14);
        chk_counts("slow", 0, 2, 2);
        chk("slow_lastSample", 0, last_s[0], 1);

        // Asymmetric path: only rising launches miss
        rise_d[0] = 14; fall_d[0] = 3;
        repeat (2) @(negedge clk);
        pulse_start(0);
        wait_done(0, 40, cyc);
        chk_counts("asym", 0, 2, 0);

        // Extra start requests during WAIT, EVAL and SETTLE are ignored
        repeat (2) @(negedge clk);
        pulse_start(0);
        start_s[0] = 1'b1;
        repeat (3) @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, 40, cyc);
        chk("busy_len", 0, cyc, 11);
        chk_counts("busyproto", 0, 2, 0);
        @(negedge clk);
        chk("busyproto_idle", 0, busy_s[0], 0);

        // Reset in the middle of a slow window
        rise_d[0] = 14; fall_d[0] = 14;
        repeat (2) @(negedge clk);
        pulse_start(0);
        repeat (8) @(negedge clk);
        chk_counts("prerst", 0, 1, 1);
        chk("prerst_pin", 0, path_in[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 0, busy_s[0], 0);
        chk("midrst_pin", 0, path_in[0], 0);
        chk("midrst_done", 0, done_s[0], 0);
        chk_counts("midrst", 0, 0, 0);
        repeat (3) @(negedge clk);

        // WINDOW=3 asymmetric: rise,fall,rise then immediate restart fall,rise,fall
        pulse_start(1);
        wait_done(1, 40, cyc);
        chk("w3_len", 1, cyc, 10);
        chk_counts("w3_first", 1, 2, 0);
        chk("w3_first_pin", 1, path_in[1], 1);
        start_s[1] = 1'b1;
        @(negedge clk);
        start_s[1] = 1'b0;
        chk("w3_restart_busy", 1, busy_s[1], 1);
        chk("w3_restart_falling", 1, path_in[1], 0);
        wait_done(1, 40, cyc);
        chk("w3_len2", 1, cyc, 10);
        chk_counts("w3_second", 1, 1, 0);
        chk("w3_second_pin", 1, path_in[1], 0);

        // Saturation with 2-bit counters over 16 slow launches
        pulse_start(2);
        wait_done(2, 100, cyc);
        chk("sat_len", 2, cyc, 62);
        chk_counts("sat", 2, 3, 3);

        // Inverting chain with INVERT=1, fast delays
        pulse_start(3);
        wait_done(3, 40, cyc);
        chk_counts("inv", 3, 0, 0);
        chk("inv_lastSample", 3, last_s[3], 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
